model_scalar_integer_accumulator: RTL and testbench
===================================================

Name: model_scalar_integer_accumulator

Overview:
- Initiator side of the scalar integer adder START/READY protocol.
- Pulls N scalars one at a time from an upstream source using a DATA_ENABLE/DATA_IN_ENABLE handshake.
- Issues one add or subtract transaction per element to an external adder responder, then returns the accumulated result with a one-cycle READY pulse.
- Sits between vector/matrix sequencers and the shared scalar adder in the NTM arithmetic tree.

Parameters:
DATA_SIZE, 64, data width of operands and accumulator
CONTROL_SIZE, 4, width of SIZE_IN (max N = 2^CONTROL_SIZE-1)
TIMEOUT_CYCLES, 16, watchdog limit in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
START  in  1  begin accumulation; sampled only in IDLE_STATE
READY  out  1  one-cycle pulse, result valid
OPERATION  in  1  0 = add, 1 = subtract; latched at START
SIZE_IN  in  CONTROL_SIZE  element count N; latched at START
DATA_IN_ENABLE  in  1  upstream presents DATA_IN this cycle
DATA_ENABLE  out  1  request for the next element
DATA_IN  in  DATA_SIZE  element value
ADDER_START  out  1  one-cycle transaction request to the adder
ADDER_READY  in  1  adder result valid
ADDER_OPERATION  out  1  operation forwarded to the adder
ADDER_DATA_A_OUT  out  DATA_SIZE  current accumulator
ADDER_DATA_B_OUT  out  DATA_SIZE  current element
ADDER_DATA_IN  in  DATA_SIZE  adder result
ADDER_OVERFLOW_IN  in  1  adder overflow flag
DATA_OUT  out  DATA_SIZE  final accumulator
OVERFLOW_OUT  out  1  sticky OR of ADDER_OVERFLOW_IN over the run

Behaviour:
- Reset (RST = 1, asynchronous): every output is 0, accumulator is 0, index is 0, sticky overflow is 0, FSM is IDLE_STATE. Reset mid-run abandons the run. A late ADDER_READY arriving after reset is ignored.
- All outputs are registered.
- IDLE_STATE:
  - READY <= 0.
  - On START = 1: latch SIZE_IN and OPERATION; clear accumulator, index and sticky overflow.
  - If SIZE_IN = 0: go to ENDER_STATE (no adder transactions).
  - Otherwise: DATA_ENABLE <= 1 and go to INPUT_STATE.
- INPUT_STATE:
  - DATA_ENABLE stays high until an element is accepted.
  - On DATA_IN_ENABLE = 1: ADDER_DATA_A_OUT <= accumulator; ADDER_DATA_B_OUT <= DATA_IN; ADDER_OPERATION <= latched OPERATION; ADDER_START <= 1; DATA_ENABLE <= 0; go to WAIT_STATE.
  - DATA_IN is ignored while DATA_IN_ENABLE = 0.
- WAIT_STATE:
  - ADDER_START <= 0, so ADDER_START is exactly one cycle wide.
  - Wait indefinitely for ADDER_READY = 1. When it arrives: accumulator <= ADDER_DATA_IN; sticky overflow |= ADDER_OVERFLOW_IN.
  - If index = N-1: go to ENDER_STATE.
  - Otherwise: index++, DATA_ENABLE <= 1, go to INPUT_STATE.
- ENDER_STATE:
  - DATA_OUT <= accumulator; OVERFLOW_OUT <= sticky overflow; READY <= 1; go to IDLE_STATE.
  - DATA_OUT and OVERFLOW_OUT hold their values until the next ENDER_STATE or reset.
- Arithmetic:
  - Performed entirely by the adder; the accumulator wraps modulo 2^DATA_SIZE.
  - With OPERATION = 1 the result is 0 - x0 - x1 - ... - x(N-1).
- Ignored inputs:
  - START while not in IDLE_STATE.
  - ADDER_READY outside WAIT_STATE.
  - DATA_IN_ENABLE outside INPUT_STATE.
- START asserted in the same cycle READY pulses is accepted on the next edge, because the FSM is in IDLE_STATE by then.
- Latency, with zero-wait upstream and the 2-cycle team adder:
  - 4 cycles per element.
  - READY rises 4*N+1 edges after the edge that samples START; for N = 0 this is 1 edge.

Optional Feature:
- Macro: MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_STATE. If TIMEOUT_CYCLES cycles pass without ADDER_READY, go to ENDER_STATE.
  - DATA_OUT gets the last good accumulator; OVERFLOW_OUT is forced to 1.
  - No further elements are requested.
  - The counter clears on each entry to WAIT_STATE.
- When undefined: no counter, and WAIT_STATE waits forever.

Test Plan:
- N = 3, OPERATION = 0, data 5, 7, 10, zero-wait upstream, team adder -> DATA_OUT = 22, OVERFLOW_OUT = 0, READY one cycle wide, 13 edges after START, exactly 3 ADDER_START pulses.
- N = 2, OPERATION = 1, data 4, 6 -> DATA_OUT = -10 (0xFFFF_FFFF_FFFF_FFF6), OVERFLOW_OUT = 0.
- N = 0 -> READY on the next edge, DATA_OUT = 0, no DATA_ENABLE and no ADDER_START.
- N = 2, upstream withholds DATA_IN_ENABLE for 5 cycles per element, START re-pulsed mid-run -> DATA_ENABLE held high during the stalls, result correct, the mid-run START has no effect.
- Stub adder returns ADDER_OVERFLOW_IN = 1 on element 1 of 3 -> OVERFLOW_OUT = 1 at READY; next run with clean data -> OVERFLOW_OUT = 0.
- Assert RST in WAIT_STATE, then the stub returns ADDER_READY -> all outputs stay 0, FSM stays idle. With the macro and a stub that never answers: READY fires 16 cycles after ADDER_START with OVERFLOW_OUT = 1.

Source files
------------

// File: rtl/model_scalar_integer_accumulator_if.sv
// =====================================================================
// Module   : model_scalar_integer_accumulator_if
// Brief    : Control, upstream-data and adder-side signals of the accumulator
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

interface model_scalar_integer_accumulator_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
);
  logic                    START;
  logic                    READY;
  logic                    OPERATION;
  logic [CONTROL_SIZE-1:0] SIZE_IN;
  logic                    DATA_IN_ENABLE;
  logic                    DATA_ENABLE;
  logic [DATA_SIZE-1:0]    DATA_IN;
  logic                    ADDER_START;
  logic                    ADDER_READY;
  logic                    ADDER_OPERATION;
  logic [DATA_SIZE-1:0]    ADDER_DATA_A_OUT;
  logic [DATA_SIZE-1:0]    ADDER_DATA_B_OUT;
  logic [DATA_SIZE-1:0]    ADDER_DATA_IN;
  logic                    ADDER_OVERFLOW_IN;
  logic [DATA_SIZE-1:0]    DATA_OUT;
  logic                    OVERFLOW_OUT;

  // Environment side: sequencer, upstream source and adder responder
  modport master (
    output START, OPERATION, SIZE_IN, DATA_IN_ENABLE, DATA_IN,
           ADDER_READY, ADDER_DATA_IN, ADDER_OVERFLOW_IN,
    input  READY, DATA_ENABLE, ADDER_START, ADDER_OPERATION,
           ADDER_DATA_A_OUT, ADDER_DATA_B_OUT, DATA_OUT, OVERFLOW_OUT
  );

  modport slave (
    input  START, OPERATION, SIZE_IN, DATA_IN_ENABLE, DATA_IN,
           ADDER_READY, ADDER_DATA_IN, ADDER_OVERFLOW_IN,
    output READY, DATA_ENABLE, ADDER_START, ADDER_OPERATION,
           ADDER_DATA_A_OUT, ADDER_DATA_B_OUT, DATA_OUT, OVERFLOW_OUT
  );
endinterface

`default_nettype wire

// File: rtl/model_scalar_integer_accumulator.sv
// =====================================================================
// Module   : model_scalar_integer_accumulator
// Brief    : Pulls N scalars and folds them through an external adder.
//            Optional watchdog: MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module model_scalar_integer_accumulator #(
  parameter int DATA_SIZE      = 64,
  parameter int CONTROL_SIZE   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              CLK,
  input  logic                              RST,
  model_scalar_integer_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_STATE  = 2'd0,
    INPUT_STATE = 2'd1,
    WAIT_STATE  = 2'd2,
    ENDER_STATE = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                  r_state, w_state;
  logic [CONTROL_SIZE-1:0] r_size, w_size;
  logic [CONTROL_SIZE-1:0] r_idx, w_idx;
  logic                    r_op, w_op;
  logic                    r_ovf, w_ovf;
  logic [DATA_SIZE-1:0]    r_acc, w_acc;
  logic [DATA_SIZE-1:0]    r_a, w_a;
  logic [DATA_SIZE-1:0]    r_b, w_b;
  logic [DATA_SIZE-1:0]    r_data_out, w_data_out;
  logic                    r_ovf_out, w_ovf_out;
  logic                    r_ready, w_ready;
  logic                    r_data_enable, w_data_enable;
  logic                    r_adder_start, w_adder_start;
  logic                    r_adder_op, w_adder_op;

`ifdef MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
  localparam int          c_TMO_W    = $clog2(TIMEOUT_CYCLES);
  // Leaving on this count puts READY exactly TIMEOUT_CYCLES after ADDER_START
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 2);
  logic [c_TMO_W-1:0] r_tmo_cnt, w_tmo_cnt;
`endif

  always_comb begin
    w_state       = r_state;
    w_size        = r_size;
    w_idx         = r_idx;
    w_op          = r_op;
    w_ovf         = r_ovf;
    w_acc         = r_acc;
    w_a           = r_a;
    w_b           = r_b;
    w_data_out    = r_data_out;
    w_ovf_out     = r_ovf_out;
    w_ready       = 1'b0;
    w_data_enable = r_data_enable;
    w_adder_start = 1'b0;
    w_adder_op    = r_adder_op;
`ifdef MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
    w_tmo_cnt     = r_tmo_cnt;
`endif
    case (r_state)
      IDLE_STATE: begin
        if (bus.START) begin
          w_size = bus.SIZE_IN;
          w_op   = bus.OPERATION;
          w_acc  = '0;
          w_idx  = '0;
          w_ovf  = 1'b0;
          if (bus.SIZE_IN == '0) begin
            w_state = ENDER_STATE;
          end else begin
            w_data_enable = 1'b1;
            w_state       = INPUT_STATE;
          end
        end
      end
      INPUT_STATE: begin
        if (bus.DATA_IN_ENABLE) begin
          w_a           = r_acc;
          w_b           = bus.DATA_IN;
          w_adder_op    = r_op;
          w_adder_start = 1'b1;
          w_data_enable = 1'b0;
          w_state       = WAIT_STATE;
`ifdef MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
          w_tmo_cnt     = '0;
`endif
        end
      end
      WAIT_STATE: begin
        if (bus.ADDER_READY) begin
          w_acc = bus.ADDER_DATA_IN;
          w_ovf = r_ovf | bus.ADDER_OVERFLOW_IN;
          if (r_idx == r_size - 1'b1) begin
            w_state = ENDER_STATE;
          end else begin
            w_idx         = r_idx + 1'b1;
            w_data_enable = 1'b1;
            w_state       = INPUT_STATE;
          end
        end
`ifdef MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
        else if (r_tmo_cnt == c_TMO_LAST) begin
          w_ovf   = 1'b1;
          w_state = ENDER_STATE;
        end else begin
          w_tmo_cnt = r_tmo_cnt + 1'b1;
        end
`endif
      end
      ENDER_STATE: begin
        w_data_out = r_acc;
        w_ovf_out  = r_ovf;
        w_ready    = 1'b1;
        w_state    = IDLE_STATE;
      end
      default: w_state = IDLE_STATE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE_STATE;
      r_size        <= '0;
      r_idx         <= '0;
      r_op          <= 1'b0;
      r_ovf         <= 1'b0;
      r_acc         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_data_out    <= '0;
      r_ovf_out     <= 1'b0;
      r_ready       <= 1'b0;
      r_data_enable <= 1'b0;
      r_adder_start <= 1'b0;
      r_adder_op    <= 1'b0;
`ifdef MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      r_state       <= w_state;
      r_size        <= w_size;
      r_idx         <= w_idx;
      r_op          <= w_op;
      r_ovf         <= w_ovf;
      r_acc         <= w_acc;
      r_a           <= w_a;
      r_b           <= w_b;
      r_data_out    <= w_data_out;
      r_ovf_out     <= w_ovf_out;
      r_ready       <= w_ready;
      r_data_enable <= w_data_enable;
      r_adder_start <= w_adder_start;
      r_adder_op    <= w_adder_op;
`ifdef MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
      r_tmo_cnt     <= w_tmo_cnt;
`endif
    end
  end

  assign bus.READY            = r_ready;
  assign bus.DATA_ENABLE      = r_data_enable;
  assign bus.ADDER_START      = r_adder_start;
  assign bus.ADDER_OPERATION  = r_adder_op;
  assign bus.ADDER_DATA_A_OUT = r_a;
  assign bus.ADDER_DATA_B_OUT = r_b;
  assign bus.DATA_OUT         = r_data_out;
  assign bus.OVERFLOW_OUT     = r_ovf_out;

endmodule

`default_nettype wire

// File: tb/tb_model_scalar_integer_accumulator.sv
// =====================================================================
// Module   : tb_model_scalar_integer_accumulator
// Brief    : Randomized bench with upstream source, adder responder and result model
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module tb_model_scalar_integer_accumulator;
  localparam int DW = 64;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;

  model_scalar_integer_accumulator_if #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) bus();

  model_scalar_integer_accumulator #(
    .DATA_SIZE(DW), .CONTROL_SIZE(CW), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Run description and behavioural model
  logic [63:0] elem [16];
  logic [63:0] pref [16];
  bit          ovf_flag [16];
  int          m_n, never_k, stall_fix;
  bit          m_op, noise, rsp_rand, late_ready;
  logic [63:0] exp_data, held_data;
  bit          exp_ovf, held_ovf;

  // Shared counters between monitor/stimulus processes
  int up_idx, rsp_idx, rsp_k, pending, stall_left;
  bit presenting, in_req, prev_ready;
  int ready_cnt, ready_cyc, astart_cnt, astart_cyc, de_cnt;

  task automatic compute_model(input int n, input bit op);
    logic [63:0] acc;
    bit o;
    acc = 64'd0;
    o   = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc     = op ? acc - elem[i] : acc + elem[i];
      pref[i] = acc;
      o       = o | ovf_flag[i];
    end
    m_n  = n;
    m_op = op;
    if (never_k >= 0 && never_k < n) begin
      exp_data = (never_k == 0) ? 64'd0 : pref[never_k-1];
      exp_ovf  = 1'b1;
    end else begin
      exp_data = acc;
      exp_ovf  = o;
    end
  endtask

  task automatic clear_cfg();
    noise = 0; rsp_rand = 0; never_k = -1; stall_fix = 0; late_ready = 0;
    for (int i = 0; i < 16; i++) ovf_flag[i] = 1'b0;
  endtask

  task automatic rand_elems(input int n);
    for (int i = 0; i < n; i++) elem[i] = {$urandom, $urandom};
  endtask

  // Upstream source: honours DATA_ENABLE, optionally stalls, adds noise when not requested
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      bus.DATA_IN_ENABLE = 1'b0;
      bus.DATA_IN        = '0;
      presenting = 0;
      in_req     = 0;
    end else begin
      if (presenting) begin
        presenting = 0;
        up_idx++;
      end
      if (in_req) chk("de_hold", 64'(bus.DATA_ENABLE), 64'd1);
      if (bus.DATA_ENABLE) begin
        if (!in_req) begin
          in_req     = 1;
          stall_left = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
        end
        if (stall_left > 0) begin
          stall_left--;
          bus.DATA_IN_ENABLE = 1'b0;
          bus.DATA_IN        = {$urandom, $urandom};
        end else begin
          chk("elem_idx", 64'(up_idx < m_n), 64'd1);
          bus.DATA_IN_ENABLE = 1'b1;
          bus.DATA_IN        = elem[up_idx & 15];
          presenting = 1;
          in_req     = 0;
        end
      end else begin
        in_req = 0;
        bus.DATA_IN_ENABLE = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.DATA_IN        = {$urandom, $urandom};
      end
    end
  end

  // Adder responder: returns the model's running result after a 2-cycle (or random) delay
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      bus.ADDER_READY       = 1'b0;
      bus.ADDER_OVERFLOW_IN = 1'b0;
      bus.ADDER_DATA_IN     = '0;
      pending = 0;
    end else begin
      bus.ADDER_READY       = 1'b0;
      bus.ADDER_OVERFLOW_IN = 1'b0;
      bus.ADDER_DATA_IN     = {$urandom, $urandom};
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          bus.ADDER_READY       = 1'b1;
          bus.ADDER_DATA_IN     = pref[rsp_k & 15];
          bus.ADDER_OVERFLOW_IN = ovf_flag[rsp_k & 15];
        end
      end else if (noise && bus.DATA_ENABLE) begin
        bus.ADDER_READY       = 1'($urandom_range(0, 1));
        bus.ADDER_OVERFLOW_IN = 1'($urandom_range(0, 1));
      end
      if (late_ready) begin
        bus.ADDER_READY       = 1'b1;
        bus.ADDER_OVERFLOW_IN = 1'b1;
      end
      if (bus.ADDER_START) begin
        rsp_k = rsp_idx;
        rsp_idx++;
        chk("start_idx", 64'(rsp_k < m_n), 64'd1);
        chk("adder_a", bus.ADDER_DATA_A_OUT, (rsp_k == 0) ? 64'd0 : pref[(rsp_k-1) & 15]);
        chk("adder_b", bus.ADDER_DATA_B_OUT, elem[rsp_k & 15]);
        chk("adder_op", 64'(bus.ADDER_OPERATION), 64'(m_op));
        if (rsp_k == never_k) pending = 0;
        else pending = rsp_rand ? int'($urandom_range(2, 5)) : 2;
      end
    end
  end

  // Compare process: every cycle, outputs against the model
  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_ready", 64'(bus.READY), 64'd0);
      chk("rst_de", 64'(bus.DATA_ENABLE), 64'd0);
      chk("rst_astart", 64'(bus.ADDER_START), 64'd0);
      chk("rst_aop", 64'(bus.ADDER_OPERATION), 64'd0);
      chk("rst_a", bus.ADDER_DATA_A_OUT, 64'd0);
      chk("rst_b", bus.ADDER_DATA_B_OUT, 64'd0);
      chk("rst_dout", bus.DATA_OUT, 64'd0);
      chk("rst_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);
      held_data  = 64'd0;
      held_ovf   = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.ADDER_START) begin
        astart_cnt++;
        astart_cyc = cyc;
      end
      if (bus.DATA_ENABLE) de_cnt++;
      if (bus.READY) begin
        ready_cnt++;
        ready_cyc = cyc;
        held_data = exp_data;
        held_ovf  = exp_ovf;
      end
      chk("ready_width", 64'(prev_ready & bus.READY), 64'd0);
      chk("data_out", bus.DATA_OUT, held_data);
      chk("ovf_out", 64'(bus.OVERFLOW_OUT), 64'(held_ovf));
      prev_ready = bus.READY;
    end
  end

  task automatic run(input int n, input bit op, input bit mid_start,
                     input int lat, input int exp_starts);
    int e0;
    compute_model(n, op);
    up_idx = 0; rsp_idx = 0;
    ready_cnt = 0; astart_cnt = 0; de_cnt = 0;
    @(negedge CLK); #1;
    bus.START = 1'b1; bus.SIZE_IN = CW'(n); bus.OPERATION = op;
    e0 = cyc + 1;
    @(negedge CLK); #1;
    bus.START = 1'b0; bus.SIZE_IN = CW'($urandom); bus.OPERATION = 1'($urandom);
    for (int t = 0; t < 2000 && ready_cnt == 0; t++) begin
      bus.START = mid_start && (t == 6);
      @(negedge CLK); #1;
    end
    bus.START = 1'b0;
    chk("ready_seen", 64'(ready_cnt), 64'd1);
    repeat (2) begin @(negedge CLK); #1; end
    chk("ready_once", 64'(ready_cnt), 64'd1);
    chk("astart_cnt", 64'(astart_cnt), 64'(exp_starts));
    chk("de_none", 64'(de_cnt == 0), 64'(n == 0));
    if (lat >= 0) chk("latency", 64'(ready_cyc - e0), 64'(lat));
  endtask

  initial begin
    bus.START = 1'b0; bus.SIZE_IN = '0; bus.OPERATION = 1'b0;
    clear_cfg();
    m_n = 0; m_op = 0; exp_data = 0; exp_ovf = 0; held_data = 0; held_ovf = 0;
    for (int i = 0; i < 16; i++) begin elem[i] = 0; pref[i] = 0; end
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    #1 RST = 1'b0;

    // N=3 add, zero-wait upstream, team adder
    elem[0] = 64'd5; elem[1] = 64'd7; elem[2] = 64'd10;
    run(3, 1'b0, 1'b0, 13, 3);
    chk("t1_data", bus.DATA_OUT, 64'd22);
    chk("t1_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);

    // N=2 subtract
    elem[0] = 64'd4; elem[1] = 64'd6;
    run(2, 1'b1, 1'b0, 9, 2);
    chk("t2_data", bus.DATA_OUT, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("t2_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);

    // N=0
    run(0, 1'b0, 1'b0, 1, 0);
    chk("t3_data", bus.DATA_OUT, 64'd0);

    // Stalled upstream plus a START pulse mid-run
    stall_fix = 5;
    elem[0] = 64'd100; elem[1] = 64'd23;
    run(2, 1'b0, 1'b1, -1, 2);
    chk("t4_data", bus.DATA_OUT, 64'd123);
    stall_fix = 0;

    // Overflow on element 1 of 3, then a clean run
    ovf_flag[1] = 1'b1;
    rand_elems(3);
    run(3, 1'b0, 1'b0, 13, 3);
    chk("t5_ovf", 64'(bus.OVERFLOW_OUT), 64'd1);
    ovf_flag[1] = 1'b0;
    rand_elems(3);
    run(3, 1'b0, 1'b0, 13, 3);
    chk("t5_clean", 64'(bus.OVERFLOW_OUT), 64'd0);

    // Reset while waiting on the adder, then a late ADDER_READY
    never_k = 0;
    rand_elems(3);
    compute_model(3, 1'b0);
    up_idx = 0; rsp_idx = 0; astart_cnt = 0;
    @(negedge CLK); #1;
    bus.START = 1'b1; bus.SIZE_IN = CW'(3); bus.OPERATION = 1'b0;
    @(negedge CLK); #1;
    bus.START = 1'b0;
    for (int t = 0; t < 50 && astart_cnt == 0; t++) begin @(negedge CLK); #1; end
    chk("rst_wait_start", 64'(astart_cnt), 64'd1);
    repeat (2) begin @(negedge CLK); #1; end
    RST = 1'b1;
    @(negedge CLK); #1;
    RST = 1'b0;
    late_ready = 1'b1;
    repeat (2) begin @(negedge CLK); #1; end
    late_ready = 1'b0;
    repeat (3) begin
      @(negedge CLK); #1;
      chk("post_rst_ready", 64'(bus.READY), 64'd0);
      chk("post_rst_de", 64'(bus.DATA_ENABLE), 64'd0);
      chk("post_rst_astart", 64'(bus.ADDER_START), 64'd0);
      chk("post_rst_dout", bus.DATA_OUT, 64'd0);
      chk("post_rst_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);
    end
    never_k = -1;

`ifdef MODEL_SCALAR_INTEGER_ACCUMULATOR_TIMEOUT_EN
    // Adder never answers element 1: watchdog ends the run
    never_k = 1;
    elem[0] = 64'd9; elem[1] = 64'd1; elem[2] = 64'd2;
    run(3, 1'b0, 1'b0, -1, 2);
    chk("tmo_delay", 64'(ready_cyc - astart_cyc), 64'd16);
    chk("tmo_data", bus.DATA_OUT, 64'd9);
    chk("tmo_ovf", 64'(bus.OVERFLOW_OUT), 64'd1);
    never_k = -1;
`endif

    // Randomized runs with noise, random stalls and random adder latency
    noise = 1; rsp_rand = 1; stall_fix = -1;
    for (int r = 0; r < 40; r++) begin
      int n;
      n = int'($urandom_range(0, 15));
      rand_elems(n);
      for (int i = 0; i < 16; i++) ovf_flag[i] = ($urandom_range(0, 7) == 0);
      run(n, 1'($urandom), 1'($urandom), -1, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
